// File: rtl/nabp_mode_sequencer.sv
// rtl/nabp_mode_sequencer.sv - angle sweep sequencer with registered per-angle scan/buffer mode (option: NABP_MODE_SEQ_ANGLE_LOAD_EN)
module nabp_mode_sequencer #(
    parameter int ANGLE_WIDTH = 10,
    parameter int ANGLE_180   = 512,
    parameter int ANGLE_STEP  = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   angle_done,
`ifdef NABP_MODE_SEQ_ANGLE_LOAD_EN
    input  logic                   angle_load,
    input  logic [ANGLE_WIDTH-1:0] angle_in,
`endif
    output logic                   busy,
    output logic                   mode_valid,
    output logic [ANGLE_WIDTH-1:0] angle,
    output logic [1:0]             sector,
    output logic                   scan_mode,
    output logic                   scan_direction,
    output logic                   buff_step_mode,
    output logic                   buff_step_direction,
    output logic                   sweep_done
);

    localparam logic [ANGLE_WIDTH-1:0] A45  = ANGLE_WIDTH'(ANGLE_180 / 4);
    localparam logic [ANGLE_WIDTH-1:0] A90  = ANGLE_WIDTH'(ANGLE_180 / 2);
    localparam logic [ANGLE_WIDTH-1:0] A135 = ANGLE_WIDTH'((3 * ANGLE_180) / 4);
    localparam logic [ANGLE_WIDTH:0]   A180_WIDE = (ANGLE_WIDTH + 1)'(ANGLE_180);
    localparam logic [ANGLE_WIDTH:0]   STEP_WIDE = (ANGLE_WIDTH + 1)'(ANGLE_STEP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ACTIVE,
        S_DONE
    } state_t;

    state_t                 state_q;
    logic                   busy_q;
    logic                   mode_valid_q;
    logic                   sweep_done_q;
    logic [ANGLE_WIDTH-1:0] angle_q;
    logic [1:0]             sector_q;
    logic                   scan_mode_q;
    logic                   scan_direction_q;
    logic                   buff_step_mode_q;
    logic                   buff_step_direction_q;

    logic [ANGLE_WIDTH:0]   sum_d;
    logic [1:0]             sector_d;

    // Next angle one bit wider than the register so the end-of-sweep test never wraps.
    always_comb begin
        sum_d = {1'b0, angle_q} + STEP_WIDE;
    end

    // Sector of the current angle over half-open quarter intervals.
    always_comb begin
        sector_d = 2'd3;
        if (angle_q < A45) begin
            sector_d = 2'd0;
        end else if (angle_q < A90) begin
            sector_d = 2'd1;
        end else if (angle_q < A135) begin
            sector_d = 2'd2;
        end
    end

`ifdef NABP_MODE_SEQ_ANGLE_LOAD_EN
    logic [ANGLE_WIDTH-1:0] load_angle_d;

    // Out-of-range preload angles restart the sweep from zero.
    always_comb begin
        load_angle_d = angle_in;
        if ({1'b0, angle_in} >= A180_WIDE) begin
            load_angle_d = '0;
        end
    end
`endif

    // Sweep FSM with all outputs registered; abort wins over angle_done and the done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q               <= S_IDLE;
            busy_q                <= 1'b0;
            mode_valid_q          <= 1'b0;
            sweep_done_q          <= 1'b0;
            angle_q               <= '0;
            sector_q              <= 2'd0;
            scan_mode_q           <= 1'b0;
            scan_direction_q      <= 1'b0;
            buff_step_mode_q      <= 1'b0;
            buff_step_direction_q <= 1'b0;
        end else begin
            sweep_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
`ifdef NABP_MODE_SEQ_ANGLE_LOAD_EN
                    if (angle_load) begin
                        angle_q <= load_angle_d;
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end else
`endif
                    if (start) begin
                        angle_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        sector_q              <= sector_d;
                        scan_mode_q           <= (sector_d == 2'd1) || (sector_d == 2'd2);
                        scan_direction_q      <= sector_d[1];
                        buff_step_mode_q      <= (sector_d == 2'd1) || (sector_d == 2'd2);
                        buff_step_direction_q <= (sector_d != 2'd0);
                        mode_valid_q          <= 1'b1;
                        state_q               <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (abort) begin
                        busy_q       <= 1'b0;
                        mode_valid_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end else if (angle_done) begin
                        mode_valid_q <= 1'b0;
                        if (sum_d >= A180_WIDE) begin
                            sweep_done_q <= 1'b1;
                            state_q      <= S_DONE;
                        end else begin
                            angle_q <= sum_d[ANGLE_WIDTH-1:0];
                            state_q <= S_LOAD;
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q       <= 1'b0;
                    mode_valid_q <= 1'b0;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end

    assign busy                = busy_q;
    assign mode_valid          = mode_valid_q;
    assign sweep_done          = sweep_done_q;
    assign angle               = angle_q;
    assign sector              = sector_q;
    assign scan_mode           = scan_mode_q;
    assign scan_direction      = scan_direction_q;
    assign buff_step_mode      = buff_step_mode_q;
    assign buff_step_direction = buff_step_direction_q;

endmodule

// File: tb/tb_nabp_mode_sequencer.sv
// tb/tb_nabp_mode_sequencer.sv - self-checking bench for nabp_mode_sequencer (default step and step 100)
module tb_nabp_mode_sequencer;

    logic       clk;
    logic [1:0] start_v;
    logic [1:0] abort_v;
    logic [1:0] done_v;
    logic [1:0] rstn_v;
`ifdef NABP_MODE_SEQ_ANGLE_LOAD_EN
    logic       load_v;
    logic [9:0] ain_v;
`endif

    wire [1:0]       busy_w;
    wire [1:0]       mv_w;
    wire [1:0]       sd_w;
    wire [1:0]       sm_w;
    wire [1:0]       sdir_w;
    wire [1:0]       bm_w;
    wire [1:0]       bd_w;
    wire [1:0][9:0]  ang_w;
    wire [1:0][1:0]  sec_w;

    int n_checks = 0;
    int n_fail   = 0;

    nabp_mode_sequencer dut0 (
        .clk(clk), .reset_n(rstn_v[0]), .start(start_v[0]), .abort(abort_v[0]), .angle_done(done_v[0]),
`ifdef NABP_MODE_SEQ_ANGLE_LOAD_EN
        .angle_load(load_v), .angle_in(ain_v),
`endif
        .busy(busy_w[0]), .mode_valid(mv_w[0]), .angle(ang_w[0]), .sector(sec_w[0]),
        .scan_mode(sm_w[0]), .scan_direction(sdir_w[0]), .buff_step_mode(bm_w[0]),
        .buff_step_direction(bd_w[0]), .sweep_done(sd_w[0])
    );

    nabp_mode_sequencer #(.ANGLE_WIDTH(10), .ANGLE_180(512), .ANGLE_STEP(100)) dut1 (
        .clk(clk), .reset_n(rstn_v[1]), .start(start_v[1]), .abort(abort_v[1]), .angle_done(done_v[1]),
`ifdef NABP_MODE_SEQ_ANGLE_LOAD_EN
        .angle_load(1'b0), .angle_in(10'd0),
`endif
        .busy(busy_w[1]), .mode_valid(mv_w[1]), .angle(ang_w[1]), .sector(sec_w[1]),
        .scan_mode(sm_w[1]), .scan_direction(sdir_w[1]), .buff_step_mode(bm_w[1]),
        .buff_step_direction(bd_w[1]), .sweep_done(sd_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int id, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d, expected %0d at %0t", nm, id, act, exp, $time);
        end
    endtask

    // Mode from the angle: quadrant index by integer division, then the per-sector table.
    function automatic logic [5:0] model_mode(input int a);
        int   s;
        logic sm;
        s  = (a * 4) / 512;
        sm = (s == 1) || (s == 2);
        return {s[1:0], sm, (s >= 2), sm, (s != 0)};
    endfunction

    function automatic int step_of(input int id);
        return (id == 0) ? 4 : 100;
    endfunction

    function automatic logic [5:0] dut_mode(input int id);
        return {sec_w[id], sm_w[id], sdir_w[id], bm_w[id], bd_w[id]};
    endfunction

    // Event timeline model: which cycle each output is due, advanced on every clock edge.
    int cyc = 0;
    int running[2]    = '{0, 0};
    int valid_from[2] = '{-1, -1};
    int done_at[2]    = '{-1, -1};
    int cur[2]        = '{0, 0};

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (!rstn_v[i]) begin
                running[i] = 0; valid_from[i] = -1; done_at[i] = -1; cur[i] = 0;
            end else if (running[i] == 0) begin
`ifdef NABP_MODE_SEQ_ANGLE_LOAD_EN
                if (i == 0 && load_v) begin
                    running[i] = 1; done_at[i] = -1; valid_from[i] = cyc + 1;
                    cur[i] = (int'(ain_v) >= 512) ? 0 : int'(ain_v);
                end else
`endif
                if (start_v[i]) begin
                    running[i] = 1; done_at[i] = -1; valid_from[i] = cyc + 1; cur[i] = 0;
                end
            end else if (done_at[i] >= 0 && cyc == done_at[i] + 1) begin
                running[i] = 0;
            end else if (abort_v[i]) begin
                running[i] = 0; valid_from[i] = -1; done_at[i] = -1;
            end else if (done_v[i] && valid_from[i] >= 0 && cyc - 1 >= valid_from[i]) begin
                if (cur[i] + step_of(i) >= 512) begin
                    valid_from[i] = -1; done_at[i] = cyc;
                end else begin
                    cur[i] += step_of(i); valid_from[i] = cyc + 1;
                end
            end
        end
    end

    logic [5:0] snap[2] = '{6'd0, 6'd0};
    int         sd_cnt[2] = '{0, 0};

    // Compare process: every output of both instances against the model on each falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int exp_mv;
            int exp_sd;
            exp_mv = (running[i] != 0 && valid_from[i] >= 0 && cyc >= valid_from[i]) ? 1 : 0;
            exp_sd = (running[i] != 0 && done_at[i] == cyc) ? 1 : 0;
            if (!rstn_v[i]) snap[i] = 6'd0;
            check("busy", i, int'(busy_w[i]), running[i]);
            check("mode_valid", i, int'(mv_w[i]), exp_mv);
            check("sweep_done", i, int'(sd_w[i]), exp_sd);
            check("angle_range", i, (int'(ang_w[i]) < 512) ? 1 : 0, 1);
            if (exp_mv != 0) begin
                snap[i] = model_mode(cur[i]);
                check("angle", i, int'(ang_w[i]), cur[i]);
            end
            check("mode", i, int'(dut_mode(i)), int'(snap[i]));
            if (sd_w[i]) sd_cnt[i]++;
        end
    end

    int         ang_log[$];
    logic [5:0] mode_log[$];

    // One sweep: start, answer each mode_valid one cycle later, optional abort at a given angle.
    task automatic sweep(input int id, input int abort_angle, output int n_ang);
        int guard;
        n_ang = 0;
        ang_log.delete();
        mode_log.delete();
        @(negedge clk);
        start_v[id] = 1'b1;
        @(posedge clk); #1;
        start_v[id] = 1'b0;
        check("start_busy", id, int'(busy_w[id]), 1);
        check("start_mv", id, int'(mv_w[id]), 0);
        while (1) begin
            guard = 0;
            while (!mv_w[id] && !sd_w[id] && guard < 10) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 10) begin
                check("wait_timeout", id, guard, 0);
                break;
            end
            if (sd_w[id]) begin
                check("done_busy", id, int'(busy_w[id]), 1);
                @(posedge clk); #1;
                check("end_busy", id, int'(busy_w[id]), 0);
                check("end_sd", id, int'(sd_w[id]), 0);
                break;
            end
            ang_log.push_back(int'(ang_w[id]));
            mode_log.push_back(dut_mode(id));
            n_ang++;
            if (int'(ang_w[id]) == abort_angle) begin
                abort_v[id] = 1'b1;
                @(posedge clk); #1;
                abort_v[id] = 1'b0;
                check("abort_busy", id, int'(busy_w[id]), 0);
                check("abort_mv", id, int'(mv_w[id]), 0);
                break;
            end
            @(negedge clk);
            done_v[id] = 1'b1;
            @(posedge clk); #1;
            done_v[id] = 1'b0;
            check("ack_mv_drop", id, int'(mv_w[id]), 0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int s_first[4];
        int guard;
        start_v = 2'b00; abort_v = 2'b00; done_v = 2'b00; rstn_v = 2'b00;
`ifdef NABP_MODE_SEQ_ANGLE_LOAD_EN
        load_v = 1'b0; ain_v = 10'd0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 0, int'(busy_w[0]), 0);
        check("rst_angle", 0, int'(ang_w[0]), 0);
        check("rst_mode", 0, int'(dut_mode(0)), 0);
        rstn_v = 2'b11;
        repeat (2) @(negedge clk);

        // Full default sweep
        sweep(0, -1, n);
        check("n_angles", 0, n, 128);
        check("first_angle", 0, ang_log[0], 0);
        check("mode_at_0", 0, int'(mode_log[0]), 6'b000000);
        check("last_angle", 0, ang_log[127], 508);
        check("mode_at_508", 0, int'(mode_log[127]), 6'b110101);
        for (int s = 0; s < 4; s++) s_first[s] = -1;
        for (int j = 0; j < ang_log.size(); j++)
            if (s_first[mode_log[j][5:4]] < 0) s_first[mode_log[j][5:4]] = ang_log[j];
        check("sector_b_start", 0, s_first[1], 128);
        check("sector_c_start", 0, s_first[2], 256);
        check("sector_d_start", 0, s_first[3], 384);
        check("sd_pulses", 0, sd_cnt[0], 1);

        // Abort at angle 200, then restart from zero
        sweep(0, 200, n);
        check("abort_n_angles", 0, n, 51);
        repeat (3) @(negedge clk);
        check("abort_no_sd", 0, sd_cnt[0], 1);
        check("abort_idle", 0, int'(busy_w[0]), 0);
        sweep(0, -1, n);
        check("restart_first", 0, ang_log[0], 0);
        check("restart_n", 0, n, 128);
        check("sd_pulses2", 0, sd_cnt[0], 2);

        // Coarse step: 0,100,...,500
        sweep(1, -1, n);
        check("step100_n", 1, n, 6);
        for (int j = 0; j < ang_log.size(); j++) check("step100_angle", 1, ang_log[j], j * 100);
        check("step100_sd", 1, sd_cnt[1], 1);

        // Asynchronous reset in ACTIVE with angle_done high
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        guard = 0;
        while (!mv_w[0] && guard < 10) begin @(negedge clk); guard++; end
        check("rst_test_mv", 0, int'(mv_w[0]), 1);
        @(negedge clk);
        done_v[0] = 1'b1;
        #2 rstn_v[0] = 1'b0;
        #1;
        check("arst_busy", 0, int'(busy_w[0]), 0);
        check("arst_mv", 0, int'(mv_w[0]), 0);
        check("arst_angle", 0, int'(ang_w[0]), 0);
        check("arst_mode", 0, int'(dut_mode(0)), 0);
        check("arst_sd", 0, int'(sd_w[0]), 0);
        @(negedge clk);
        done_v[0] = 1'b0;
        rstn_v[0] = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_busy", 0, int'(busy_w[0]), 0);
        check("post_rst_mv", 0, int'(mv_w[0]), 0);

`ifdef NABP_MODE_SEQ_ANGLE_LOAD_EN
        // Preloaded starts: 384 lands in sector d, 600 clamps to zero
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            load_v = 1'b1;
            ain_v  = (t == 0) ? 10'd384 : 10'd600;
            @(posedge clk); #1;
            load_v = 1'b0;
            guard = 0;
            while (!mv_w[0] && guard < 10) begin @(negedge clk); guard++; end
            check("load_mv", 0, int'(mv_w[0]), 1);
            check("load_angle", 0, int'(ang_w[0]), (t == 0) ? 384 : 0);
            check("load_sector", 0, int'(sec_w[0]), (t == 0) ? 3 : 0);
            abort_v[0] = 1'b1;
            @(posedge clk); #1;
            abort_v[0] = 1'b0;
        end
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
